axis_to_pull: RTL

//  Converts an AXI-stream input into a pull interface driven by a consumer read strobe (e.g. DAC/UART sample tick).

---
 rtl/axis_to_pull_pkg.sv | 10 +
 rtl/simple_dual_port_ram_reg1.sv | 42 ++++
 rtl/axis_to_pull.sv | 92 +++++++++
 3 files changed

// File: rtl/axis_to_pull_pkg.sv
// Shared definitions for the stream <-> pull adapters.
// Holds the default almost-empty threshold expression, which the push path uses as well.
package axis_to_pull_pkg;

  // Default almost-empty threshold: half of the RAM depth.
  function automatic int unsigned default_aempty_limit(input int unsigned addr_width);
    return 32'(1) << (addr_width - 1);
  endfunction

endpackage

// File: rtl/simple_dual_port_ram_reg1.sv
// Simple dual-port RAM with one write port and one registered read port.
// Both ports use the same clock.
// Ports:
//   clock   in   write and read clock (rising edge)
//   wenable in   write strobe
//   waddr   in   write address
//   wdata   in   write data
//   renable in   read strobe; rdata is loaded only when it is high
//   raddr   in   read address
//   rdata   out  registered read data; holds its value while renable is low
module simple_dual_port_ram_reg1 #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  wenable,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  renable,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clock) begin
    if (wenable) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port.
  always_ff @(posedge clock) begin
    if (renable) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/axis_to_pull.sv
// AXI-stream to pull-interface adapter.
// Words from the stream are buffered in a RAM FIFO; one word is held on odata
// and handed to the consumer on each oenable strobe. oaempty paces the source,
// underflow records any pull made while no word was held.
// Build option: AXIS_TO_PULL_ZERO_FILL_EN forces odata to 0 whenever no word is held;
// without it odata simply shows the last word read from the RAM.
// Ports:
//   clock     in   clock, rising edge
//   resetn    in   asynchronous active-low reset
//   underflow out  sticky flag: pull while no word held; cleared only by reset
//   idata     in   stream data
//   ivalid    in   stream valid
//   iready    out  stream ready (from registers only)
//   odata     out  word presented to the consumer
//   oenable   in   pull strobe: consumer takes odata at this edge
//   oaempty   out  registered almost-empty flag (RAM occupancy below AEMPTY_LIMIT)
module axis_to_pull
  import axis_to_pull_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned AEMPTY_LIMIT = default_aempty_limit(ADDR_WIDTH)
) (
  input  logic                  clock,
  input  logic                  resetn,
  output logic                  underflow,
  input  logic [DATA_WIDTH-1:0] idata,
  input  logic                  ivalid,
  output logic                  iready,
  output logic [DATA_WIDTH-1:0] odata,
  input  logic                  oenable,
  output logic                  oaempty
);

  localparam logic [ADDR_WIDTH-1:0] SIZE_FULL = '1;

  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [ADDR_WIDTH-1:0] size;
  logic                  hvalid;
  logic                  wenable;
  logic                  renable;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // RAM occupancy, excluding the held word; one slot is kept free so full != empty.
  assign size    = waddr - raddr;
  assign iready  = (size != SIZE_FULL);
  assign wenable = ivalid && iready;
  // Refill the held word when it is empty or being consumed this edge.
  assign renable = (size != '0) && (!hvalid || oenable);

  // Pointers, held-word valid and status flags.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      waddr     <= '0;
      raddr     <= '0;
      hvalid    <= 1'b0;
      underflow <= 1'b0;
      oaempty   <= 1'b1;
    end else begin
      if (wenable) begin
        waddr <= waddr + ADDR_WIDTH'(1);
      end
      if (renable) begin
        raddr <= raddr + ADDR_WIDTH'(1);
      end
      hvalid    <= renable || (hvalid && !oenable);
      underflow <= underflow || (oenable && !hvalid);
      oaempty   <= (32'(size) < AEMPTY_LIMIT);
    end
  end

  simple_dual_port_ram_reg1 #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clock   (clock),
    .wenable (wenable),
    .waddr   (waddr),
    .wdata   (idata),
    .renable (renable),
    .raddr   (raddr),
    .rdata   (ram_rdata)
  );

`ifdef AXIS_TO_PULL_ZERO_FILL_EN
  assign odata = hvalid ? ram_rdata : '0;
`else
  assign odata = ram_rdata;
`endif

endmodule
